// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the MiniAlu execution unit: opcode numbering used by
// the decoder, the execution unit and its testbench.
package alu_exec_unit_pkg;

  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_LED  = 1;
  localparam int unsigned OP_BLE  = 2;
  localparam int unsigned OP_STO  = 3;
  localparam int unsigned OP_ADD  = 4;
  localparam int unsigned OP_JMP  = 5;
  localparam int unsigned OP_SUB  = 6;
  localparam int unsigned OP_SMUL = 7;
  localparam int unsigned OP_UMUL = 8;

endpackage

// File: rtl/alu_exec_unit_seq_multiplier.sv
// Unsigned shift-add multiplier core: loads on iStart, then performs one
// add-and-shift step per cycle for WIDTH cycles.
module seq_multiplier
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic [WIDTH-1:0]   iA,
  input  logic [WIDTH-1:0]   iB,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oProduct
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   r_multiplicand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic               r_run;
  logic [WIDTH:0]     w_sum;

  // Upper half accumulates; lower half starts as the multiplier and drains out
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + (r_acc[0] ? {1'b0, r_multiplicand} : {(WIDTH+1){1'b0}});

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_multiplicand <= '0;
      r_acc          <= '0;
      r_count        <= '0;
      r_run          <= 1'b0;
    end else if (iStart) begin
      r_multiplicand <= iA;
      r_acc          <= {{WIDTH{1'b0}}, iB};
      r_count        <= '0;
      r_run          <= 1'b1;
    end else if (r_run) begin
      r_acc <= {w_sum, r_acc[WIDTH-1:1]};
      if (r_count == CW'(WIDTH - 1)) begin
        r_run   <= 1'b0;
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // High during the final step; oProduct is complete from the next cycle on
  assign oDone    = r_run && (r_count == CW'(WIDTH - 1));
  assign oProduct = r_acc;

endmodule

// File: rtl/alu_exec_unit.sv
// MiniAlu execution unit: valid/ready operation intake, single-cycle ALU ops
// and an iterative signed/unsigned multiply with registered result strobes.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iValid,
  output logic             oReady,
  input  logic [OPW-1:0]   iOperation,
  input  logic [WIDTH-1:0] iSourceData0,
  input  logic [WIDTH-1:0] iSourceData1,
  input  logic [WIDTH-1:0] iImmediate,
  output logic             oValid,
  output logic [WIDTH-1:0] oResult,
  output logic [WIDTH-1:0] oResultHI,
  output logic             oWriteEnable,
  output logic             oBranchTaken,
  output logic             oLedEnable,
  output logic             oBusy
);

  localparam logic [OPW-1:0] L_LED  = OPW'(OP_LED);
  localparam logic [OPW-1:0] L_BLE  = OPW'(OP_BLE);
  localparam logic [OPW-1:0] L_STO  = OPW'(OP_STO);
  localparam logic [OPW-1:0] L_ADD  = OPW'(OP_ADD);
  localparam logic [OPW-1:0] L_JMP  = OPW'(OP_JMP);
  localparam logic [OPW-1:0] L_SUB  = OPW'(OP_SUB);
  localparam logic [OPW-1:0] L_SMUL = OPW'(OP_SMUL);
  localparam logic [OPW-1:0] L_UMUL = OPW'(OP_UMUL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_ready;
  logic               r_busy;
  logic               r_valid;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_resultHI;
  logic               r_we;
  logic               r_branch;
  logic               r_led;
  logic               r_negate;

  logic               w_accept;
  logic               w_isSmul;
  logic               w_isMul;
  logic               w_start;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic               w_mulLast;
  logic [2*WIDTH-1:0] w_product;
  logic [2*WIDTH-1:0] w_fixed;

  assign w_accept = iValid && r_ready;
  assign w_isSmul = (iOperation == L_SMUL);
  assign w_isMul  = w_isSmul || (iOperation == L_UMUL);
  assign w_start  = w_accept && w_isMul;

  // Signed operands become unsigned magnitudes; the most-negative value maps to 2^(WIDTH-1)
  assign w_magA = (w_isSmul && iSourceData0[WIDTH-1]) ? -iSourceData0 : iSourceData0;
  assign w_magB = (w_isSmul && iSourceData1[WIDTH-1]) ? -iSourceData1 : iSourceData1;

  seq_multiplier #(
    .WIDTH(WIDTH)
  ) u_mult (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (w_start),
    .iA      (w_magA),
    .iB      (w_magB),
    .oDone   (w_mulLast),
    .oProduct(w_product)
  );

  assign w_fixed = r_negate ? -w_product : w_product;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_resultHI <= '0;
      r_we       <= 1'b0;
      r_branch   <= 1'b0;
      r_led      <= 1'b0;
      r_negate   <= 1'b0;
    end else begin
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
      r_branch <= 1'b0;
      r_led    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_isMul) begin
            r_state  <= S_MUL;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_negate <= w_isSmul && (iSourceData0[WIDTH-1] ^ iSourceData1[WIDTH-1]);
          end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_resultHI <= '0;
            case (iOperation)
              L_LED: begin
                r_result <= iSourceData1;
                r_led    <= 1'b1;
              end
              L_BLE: r_branch <= ($signed(iSourceData1) <= $signed(iSourceData0));
              L_STO: begin
                r_result <= iImmediate;
                r_we     <= 1'b1;
              end
              L_ADD: begin
                r_result <= iSourceData1 + iSourceData0;
                r_we     <= 1'b1;
              end
              L_JMP: r_branch <= 1'b1;
              L_SUB: begin
                r_result <= iSourceData1 - iSourceData0;
                r_we     <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (w_mulLast) r_state <= S_FIX;
        end
        S_FIX: begin
          {r_resultHI, r_result} <= w_fixed;
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oReady       = r_ready;
  assign oBusy        = r_busy;
  assign oValid       = r_valid;
  assign oResult      = r_result;
  assign oResultHI    = r_resultHI;
  assign oWriteEnable = r_we;
  assign oBranchTaken = r_branch;
  assign oLedEnable   = r_led;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, hand-written
// handshake/reset sequences and randomized ops against a behavioural model.
module tb_alu_exec_unit;

  localparam int W = 16;

  logic          Clock;
  logic          Reset;
  logic          iValid;
  logic          oReady;
  logic [3:0]    iOperation;
  logic [W-1:0]  iSourceData0;
  logic [W-1:0]  iSourceData1;
  logic [W-1:0]  iImmediate;
  logic          oValid;
  logic [W-1:0]  oResult;
  logic [W-1:0]  oResultHI;
  logic          oWriteEnable;
  logic          oBranchTaken;
  logic          oLedEnable;
  logic          oBusy;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] mdlLast = '0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] imm;
    logic [W-1:0] expRes;
    logic [W-1:0] expHi;
    logic         we;
    logic         br;
    logic         led;
    logic         chkRes;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         we;
    logic         br;
    logic         led;
    int           lat;
  } exp_t;

  alu_exec_unit #(.WIDTH(W), .OPW(4)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iValid      (iValid),
    .oReady      (oReady),
    .iOperation  (iOperation),
    .iSourceData0(iSourceData0),
    .iSourceData1(iSourceData1),
    .iImmediate  (iImmediate),
    .oValid      (oValid),
    .oResult     (oResult),
    .oResultHI   (oResultHI),
    .oWriteEnable(oWriteEnable),
    .oBranchTaken(oBranchTaken),
    .oLedEnable  (oLedEnable),
    .oBusy       (oBusy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Behavioural reference: arithmetic straight from the opcode definitions
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] imm);
    exp_t e;
    longint p;
    e.res = mdlLast; e.hi = '0; e.we = 0; e.br = 0; e.led = 0; e.lat = 0;
    case (op)
      4'd1: begin e.res = b; e.led = 1; end
      4'd2: e.br = ($signed(b) <= $signed(a));
      4'd3: begin e.res = imm; e.we = 1; end
      4'd4: begin e.res = W'(b + a); e.we = 1; end
      4'd5: e.br = 1;
      4'd6: begin e.res = W'(b - a); e.we = 1; end
      4'd7: begin
        p = longint'($signed(b)) * longint'($signed(a));
        e.hi = p[2*W-1:W]; e.res = p[W-1:0]; e.lat = W + 1;
      end
      4'd8: begin
        p = longint'(b) * longint'(a);
        e.hi = p[2*W-1:W]; e.res = p[W-1:0]; e.lat = W + 1;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] imm,
                               input exp_t e, input logic chkRes);
    int n;
    n = 0;
    while (!oReady && n < 100) begin tick(); n++; end
    if (n >= 100) checkOutput({name, " ready timeout"}, 0, 1);
    iValid = 1'b1; iOperation = op; iSourceData0 = a; iSourceData1 = b; iImmediate = imm;
    tick();
    iValid = 1'b0;
    if (e.lat > 0) checkOutput({name, " busy/ready"}, {oBusy, oReady}, 2'b10);
    n = 0;
    while (!oValid && n < 100) begin tick(); n++; end
    checkOutput({name, " latency"}, n, e.lat);
    if (chkRes) checkOutput({name, " result"}, oResult, e.res);
    checkOutput({name, " resultHI"}, oResultHI, e.hi);
    checkOutput({name, " strobes"}, {oWriteEnable, oBranchTaken, oLedEnable}, {e.we, e.br, e.led});
    mdlLast = e.res;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t  vecs[12];
    exp_t  e;
    logic  sawValid;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb, ri;

    vecs[0]  = '{4'd4, 16'h0001, 16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 1, 0, 0, 1};
    vecs[1]  = '{4'd6, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 0, 1};
    vecs[2]  = '{4'd7, 16'h0007, 16'hFFFD, 16'h0000, 16'hFFEB, 16'hFFFF, 0, 0, 0, 1};
    vecs[3]  = '{4'd7, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h4000, 0, 0, 0, 1};
    vecs[4]  = '{4'd8, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE, 0, 0, 0, 1};
    vecs[5]  = '{4'd2, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0};
    vecs[6]  = '{4'd2, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0};
    vecs[7]  = '{4'd2, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0};
    vecs[8]  = '{4'd5, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0};
    vecs[9]  = '{4'hF, 16'h1111, 16'h2222, 16'h3333, 16'h0000, 16'h0000, 0, 0, 0, 0};
    vecs[10] = '{4'd3, 16'h1111, 16'h2222, 16'h1234, 16'h1234, 16'h0000, 1, 0, 0, 1};
    vecs[11] = '{4'd8, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1};

    Reset = 1'b0; iValid = 1'b0; iOperation = '0;
    iSourceData0 = '0; iSourceData1 = '0; iImmediate = '0;
    #22 Reset = 1'b1;
    tick();
    checkOutput("reset outputs", {oValid, oReady, oBusy, oResult, oResultHI}, {3'b010, 32'h0});

    for (int i = 0; i < 12; i++) begin
      e = model(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm);
      e.res = vecs[i].chkRes ? vecs[i].expRes : e.res;
      e.hi = vecs[i].expHi; e.we = vecs[i].we; e.br = vecs[i].br; e.led = vecs[i].led;
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm,
                    e, vecs[i].chkRes);
    end

    // Back-to-back ADD then SUB on consecutive cycles
    iValid = 1; iOperation = 4'd4; iSourceData0 = 16'h0001; iSourceData1 = 16'h7FFF;
    tick();
    iOperation = 4'd6; iSourceData0 = 16'h0001; iSourceData1 = 16'h0000;
    checkOutput("b2b add", {oValid, oWriteEnable, oReady, oResult}, {3'b111, 16'h8000});
    tick();
    iValid = 0;
    checkOutput("b2b sub", {oValid, oWriteEnable, oResult}, {2'b11, 16'hFFFF});
    mdlLast = 16'hFFFF;

    // ADD held while SMUL is busy; operands changed after the accept edge
    iValid = 1; iOperation = 4'd7; iSourceData0 = 16'h0007; iSourceData1 = 16'hFFFD;
    tick();
    iOperation = 4'd4; iSourceData0 = 16'h0001; iSourceData1 = 16'h0002;
    begin
      int n;
      n = 0;
      while (!oValid && n < 100) begin tick(); n++; end
      checkOutput("held smul latency", n, W + 1);
      checkOutput("held smul product", {oResultHI, oResult, oReady}, {32'hFFFF_FFEB, 1'b1});
    end
    tick();
    iValid = 0;
    checkOutput("held add", {oValid, oWriteEnable, oResultHI, oResult}, {2'b11, 16'h0000, 16'h0003});
    mdlLast = 16'h0003;

    // Reset pulsed mid-multiply
    iValid = 1; iOperation = 4'd7; iSourceData0 = 16'h0003; iSourceData1 = 16'h0005;
    tick();
    iValid = 0;
    repeat (5) tick();
    Reset = 1'b0;
    #2;
    checkOutput("mid reset", {oValid, oReady, oBusy, oResult, oResultHI}, {3'b010, 32'h0});
    Reset = 1'b1;
    mdlLast = '0;
    sawValid = 1'b0;
    repeat (25) begin
      tick();
      if (oValid) sawValid = 1'b1;
    end
    checkOutput("no valid after abort", {sawValid, oReady}, 2'b01);
    e = model(4'd1, 16'h0000, 16'h00A5, 16'h0000);
    e.res = 16'h00A5; e.led = 1'b1;
    applyStimulus("led after reset", 4'd1, 16'h0000, 16'h00A5, 16'h0000, e, 1'b1);

    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      if (i % 4 == 0) rop = 4'($urandom_range(7, 8));
      ra = W'($urandom); rb = W'($urandom); ri = W'($urandom);
      e = model(rop, ra, rb, ri);
      applyStimulus($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, ri, e, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execution unit for the MiniAlu datapath. It takes one decoded operation plus operands through a valid/ready handshake and returns a registered result with write, branch and LED strobes. Single-cycle ops complete in 1 cycle. Signed and unsigned multiply run iteratively over WIDTH cycles and deliver a full 2·WIDTH product as HI/LO. It sits between the RAM read ports and the RAM write port / IP counter, replacing the combinational ALU case block.

## Interface
- WIDTH, 16, operand and result word width (≥4)
- OPW, 4, opcode width
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- iValid  in  1  operation and operands present
- oReady  out  1  unit can accept; high only in IDLE
- iOperation  in  OPW  opcode
- iSourceData0  in  WIDTH  operand A (RAM port 0)
- iSourceData1  in  WIDTH  operand B (RAM port 1)
- iImmediate  in  WIDTH  immediate for STO
- oValid  out  1  one-cycle result strobe
- oResult  out  WIDTH  result / low product word
- oResultHI  out  WIDTH  high product word; 0 for non-multiply ops
- oWriteEnable  out  1  write oResult to destination; qualified by oValid
- oBranchTaken  out  1  load IP from destination; qualified by oValid
- oLedEnable  out  1  latch oResult[7:0] into LED register; qualified by oValid
- oBusy  out  1  multiply in progress

## Operation
- Opcodes: NOP=0, LED=1, BLE=2, STO=3, ADD=4, JMP=5, SUB=6, SMUL=7, UMUL=8. All other codes are accepted and complete as a NOP, with all strobes 0. This replaces the old behaviour, where unknown opcodes lit the LED.
- Accept on the edge where iValid && oReady. Operands and opcode are captured into registers at that edge. Later input changes have no effect.
- ADD: B+A. SUB: B−A. Both wrap modulo 2^WIDTH and set oWriteEnable=1.
- STO: oResult=iImmediate, oWriteEnable=1.
- BLE: oBranchTaken = (signed B ≤ signed A).
- JMP: oBranchTaken=1.
- LED: oResult=B, oLedEnable=1.
- UMUL: unsigned B×A gives {oResultHI,oResult}.
- SMUL: signed B×A, computed from unsigned magnitudes. The result is negated when the operand signs differ. The magnitude of the most-negative value is 2^(WIDTH−1) held unsigned.
- FSM states:
  - IDLE: oReady=1. A multiply accept goes to MUL. Any other accept goes to IDLE and drives oValid next cycle.
  - MUL: one shift-add step per cycle, WIDTH steps. The step counter runs 0..WIDTH−1, then goes to FIX.
  - FIX: apply sign correction, drive oValid, go to IDLE.
- iValid while not ready is ignored; the sender must hold it.
- Result outputs hold their last value between strobes. Strobes are 0 whenever oValid=0.

## Timing
- Reset values: oValid=0, oResult=0, oResultHI=0, all strobes 0, oBusy=0, oReady=1, state=IDLE, counter=0.
- Single-cycle ops: oValid is high in the cycle after the accept edge (latency 1). oReady stays high, so back-to-back accepts every cycle are allowed.
- Multiply:
  - Accept edge is edge 0.
  - oBusy=1 and oReady=0 from edge 0 until edge WIDTH+1.
  - oValid is high in the cycle after edge WIDTH+1 (latency WIDTH+2). oReady returns high in that same cycle, so the next op may be accepted there.
- Zero operands still take the full latency; there is no early termination.
- Reset asserted mid-multiply aborts immediately. No oValid follows, and after deassertion the unit is in IDLE.

## Structure
- Opcode constants go in the shared definitions include, extended with SMUL=7 and UMUL=8.
- FSM state encodings are local localparams.
- One sub-module, seq_multiplier:
  - parameter WIDTH
  - ports: Clock, Reset, iStart, unsigned iA, unsigned iB, oDone, 2·WIDTH oProduct
  - role: the shift-add core
- The top level handles sign/magnitude conversion and the handshake.

## Test plan
- Reset with all outputs forced: after Reset low then high → oValid=0, oReady=1, oResult=0, oResultHI=0.
- ADD B=0x7FFF, A=0x0001, then SUB B=0x0000, A=0x0001 back-to-back → oResult 0x8000 then 0xFFFF on consecutive cycles, oWriteEnable=1 both times.
- SMUL B=−3, A=7 → after 18 cycles {HI,LO}=0xFFFF_FFEB. SMUL 0x8000×0x8000 → 0x4000_0000. UMUL 0xFFFF×0xFFFF → 0xFFFE_0001.
- BLE B=−1, A=0 → oBranchTaken=1. BLE B=5, A=5 → 1. BLE B=6, A=5 → 0. JMP → 1. Opcode 0xF → oValid=1 with all strobes 0.
- iValid with ADD held during SMUL busy → not accepted until oReady returns. Operands are changed after the SMUL accept edge → product unaffected.
- Reset pulsed at cycle 5 of SMUL → no oValid. A subsequent LED op with B=0x00A5 → oLedEnable=1, oResult=0x00A5.
